// File: rtl/backprop_pkg.sv
// Shared definitions for the backprop delta datapath: controller states,
// the default fixed-point fraction width and a generic saturation helper.
package backprop_pkg;

  // Controller states of the delta calculator.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Default number of fractional bits of the Q-format (Q8.8 for 16-bit data).
  localparam int DEFAULT_FRAC_BITS = 8;

  // Clamp a sign-extended 64-bit value into the signed range of a width-bit
  // word. The caller keeps the low width bits of the result.
  function automatic logic signed [63:0] saturate(input logic signed [63:0] value,
                                                  input int width);
    logic signed [63:0] max_v;
    logic signed [63:0] min_v;
    logic signed [63:0] result;
    max_v  = (64'sd1 <<< (width - 1)) - 64'sd1;
    min_v  = -(64'sd1 <<< (width - 1));
    result = value;
    if (value > max_v) begin
      result = max_v;
    end else if (value < min_v) begin
      result = min_v;
    end
    return result;
  endfunction

endpackage

// File: rtl/fx_mul_sat.sv
// Signed fixed-point multiply, arithmetic right shift by frac_bits and
// saturation back to data_size bits. Purely combinational.
// The a operand is one bit wider than the data so that a cost-layer error
// (difference of two data words) reaches the multiplier without overflow.
module fx_mul_sat
  import backprop_pkg::*;
#(
  parameter int data_size = 16,
  parameter int frac_bits = DEFAULT_FRAC_BITS
) (
  input  logic [data_size:0]   a_i,
  input  logic [data_size-1:0] b_i,
  output logic [data_size-1:0] y_o
);

  // Product of a (data_size+1 bits) and b (data_size bits) fits in PW bits.
  localparam int PW = 2 * data_size + 1;

  logic signed [PW-1:0] a_ext;
  logic signed [PW-1:0] b_ext;
  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] shifted;
  logic signed [63:0]   wide;
  logic signed [63:0]   clamped;
  logic                 unused_hi;

  // Sign-extend both operands, multiply, rescale and clamp.
  always_comb begin
    a_ext   = {{(PW - data_size - 1){a_i[data_size]}}, a_i};
    b_ext   = {{(PW - data_size){b_i[data_size-1]}}, b_i};
    prod    = a_ext * b_ext;
    shifted = prod >>> frac_bits;
    wide    = {{(64 - PW){shifted[PW-1]}}, shifted};
    clamped = saturate(wide, data_size);
    y_o     = clamped[data_size-1:0];
  end

  // Upper bits of the clamped value are pure sign copies after saturation.
  assign unused_hi = ^clamped[63:data_size];

endmodule

// File: rtl/diff_delta_calc.sv
// Backprop delta calculator: captures one bundle of per-neuron error inputs,
// computes delta[i] = sat((relu'(z[i]) * e[i] * lr) >>> frac_bits) one
// element per cycle through a single shared multiplier, then presents the
// registered delta bundle with its weight-row tags until it is taken.
//
// Timing: the gated error of element k is registered in the cycle it is
// selected and multiplied the following cycle, so a size-element bundle
// spends size+1 cycles in CALC and out_valid rises size+1 cycles after the
// accept edge.
module diff_delta_calc
  import backprop_pkg::*;
#(
  parameter int size      = 3,
  parameter int data_size = 16,
  parameter int frac_bits = DEFAULT_FRAC_BITS
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 w_layer_index,
  input  logic [31:0]                 w_row_index,
  input  logic                        is_cost_layer,
  input  logic                        is_update,
  input  logic [size*data_size-1:0]   diff_to_all,
  input  logic [size*data_size-1:0]   z,
  input  logic [size*data_size-1:0]   predict_value,
  input  logic [data_size-1:0]        learning_rate,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [size*data_size-1:0]   delta,
  output logic [31:0]                 w_layer_index_out,
  output logic [31:0]                 w_row_index_out,
  output logic                        is_update_out
);

  localparam int IDX_W = (size > 1) ? $clog2(size) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(size - 1);

  // Controller state.
  state_e state_q;
  state_e state_d;
  logic   accept;

  // Captured bundle (held constant from accept to the next accept).
  logic [data_size-1:0] diff_q  [size];
  logic [data_size-1:0] z_q     [size];
  logic [data_size-1:0] pred_q  [size];
  logic [data_size-1:0] lr_q;
  logic                 cost_q;

  // Registered output bundle, written element by element.
  logic [data_size-1:0] delta_q [size];

  // Element selection and multiplier pipeline.
  logic [IDX_W-1:0] idx_q;
  logic [IDX_W-1:0] idx_d;
  logic             issued_q;
  logic             issued_d;
  logic [data_size:0] g_q;
  logic [data_size:0] g_d;
  logic [IDX_W-1:0] g_idx_q;
  logic [IDX_W-1:0] g_idx_d;
  logic             g_vld_q;
  logic             g_vld_d;

  // Current element operands and gated error.
  logic [data_size-1:0] cur_diff;
  logic [data_size-1:0] cur_z;
  logic [data_size-1:0] cur_pred;
  logic [data_size:0]   err;
  logic [data_size:0]   gated;
  logic                 z_pos;
  logic [data_size-1:0] mul_y;

  assign accept = in_ready & in_valid;

  // Next-state logic and handshake outputs decoded from the state.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_d = ST_CALC;
        end
      end
      ST_CALC: begin
        if (g_vld_q && (g_idx_q == LAST_IDX)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Error term of the selected element, gated by the ReLU derivative of z.
  always_comb begin
    cur_diff = diff_q[idx_q];
    cur_z    = z_q[idx_q];
    cur_pred = pred_q[idx_q];
    if (cost_q) begin
      err = {cur_z[data_size-1], cur_z} - {cur_pred[data_size-1], cur_pred};
    end else begin
      err = {cur_diff[data_size-1], cur_diff};
    end
    z_pos = ~cur_z[data_size-1] & (|cur_z);
    gated = z_pos ? err : '0;
  end

  // Walk the element index and feed the multiplier pipeline register.
  always_comb begin
    idx_d    = idx_q;
    issued_d = issued_q;
    g_d      = g_q;
    g_idx_d  = g_idx_q;
    g_vld_d  = 1'b0;
    if (accept) begin
      idx_d    = '0;
      issued_d = 1'b0;
    end else if ((state_q == ST_CALC) && !issued_q) begin
      g_d     = gated;
      g_idx_d = idx_q;
      g_vld_d = 1'b1;
      if (idx_q == LAST_IDX) begin
        idx_d    = '0;
        issued_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  // State and pipeline registers; reset abandons any bundle in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      issued_q <= 1'b0;
      g_q      <= '0;
      g_idx_q  <= '0;
      g_vld_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      issued_q <= issued_d;
      g_q      <= g_d;
      g_idx_q  <= g_idx_d;
      g_vld_q  <= g_vld_d;
    end
  end

  // Capture the scalar operands and pass-through tags on accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      lr_q              <= '0;
      cost_q            <= 1'b0;
      w_layer_index_out <= '0;
      w_row_index_out   <= '0;
      is_update_out     <= 1'b0;
    end else if (accept) begin
      lr_q              <= learning_rate;
      cost_q            <= is_cost_layer;
      w_layer_index_out <= w_layer_index;
      w_row_index_out   <= w_row_index;
      is_update_out     <= is_update;
    end
  end

  // The single shared multiplier works on the registered gated error.
  fx_mul_sat #(
    .data_size (data_size),
    .frac_bits (frac_bits)
  ) u_mul (
    .a_i (g_q),
    .b_i (lr_q),
    .y_o (mul_y)
  );

  genvar gi;
  generate
    for (gi = 0; gi < size; gi++) begin : g_elem
      // Capture this element's vectors on accept.
      always_ff @(posedge clk) begin
        if (rst) begin
          diff_q[gi] <= '0;
          z_q[gi]    <= '0;
          pred_q[gi] <= '0;
        end else if (accept) begin
          diff_q[gi] <= diff_to_all[gi*data_size +: data_size];
          z_q[gi]    <= z[gi*data_size +: data_size];
          pred_q[gi] <= predict_value[gi*data_size +: data_size];
        end
      end

      // Write this element's delta in place when its product is ready.
      always_ff @(posedge clk) begin
        if (rst) begin
          delta_q[gi] <= '0;
        end else if (g_vld_q && (g_idx_q == IDX_W'(gi))) begin
          delta_q[gi] <= mul_y;
        end
      end

      assign delta[gi*data_size +: data_size] = delta_q[gi];
    end
  endgenerate

endmodule

// File: tb/tb_diff_delta_calc.sv
// Self-checking bench for diff_delta_calc: directed vectors for the worked
// examples plus randomized bundles compared against an arithmetic model.
module tb_diff_delta_calc;

  localparam int N  = 3;
  localparam int W  = 16;
  localparam int FB = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [31:0]    w_layer_index;
  logic [31:0]    w_row_index;
  logic           is_cost_layer;
  logic           is_update;
  logic [N*W-1:0] diff_to_all;
  logic [N*W-1:0] z;
  logic [N*W-1:0] predict_value;
  logic [W-1:0]   learning_rate;
  logic           out_valid;
  logic           out_ready;
  logic [N*W-1:0] delta;
  logic [31:0]    w_layer_index_out;
  logic [31:0]    w_row_index_out;
  logic           is_update_out;

  int n_checks = 0;
  int n_pass   = 0;

  // Stimulus for the next bundle.
  logic [W-1:0] s_d [N];
  logic [W-1:0] s_z [N];
  logic [W-1:0] s_p [N];
  logic [W-1:0] s_lr;
  logic         s_cost;
  logic [31:0]  s_wl;
  logic [31:0]  s_wr;
  logic         s_upd;
  logic [N*W-1:0] exp_vec;

  always #5 clk = ~clk;

  diff_delta_calc #(.size(N), .data_size(W), .frac_bits(FB)) dut (
    .clk               (clk),
    .rst               (rst),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .w_layer_index     (w_layer_index),
    .w_row_index       (w_row_index),
    .is_cost_layer     (is_cost_layer),
    .is_update         (is_update),
    .diff_to_all       (diff_to_all),
    .z                 (z),
    .predict_value     (predict_value),
    .learning_rate     (learning_rate),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .delta             (delta),
    .w_layer_index_out (w_layer_index_out),
    .w_row_index_out   (w_row_index_out),
    .is_update_out     (is_update_out)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference: ReLU-gated error, scaled by lr, floor-shifted, clamped.
  function automatic logic [W-1:0] ref_delta(input logic [W-1:0] d, input logic [W-1:0] zz,
                                             input logic [W-1:0] p, input logic cost,
                                             input logic [W-1:0] lr);
    longint e;
    longint g;
    longint r;
    longint hi;
    longint lo;
    hi = (longint'(1) <<< (W - 1)) - 1;
    lo = -(longint'(1) <<< (W - 1));
    if (cost) e = longint'($signed(zz)) - longint'($signed(p));
    else      e = longint'($signed(d));
    g = ($signed(zz) > 0) ? e : 0;
    r = (g * longint'($signed(lr))) >>> FB;
    if (r > hi) r = hi;
    if (r < lo) r = lo;
    return W'(r);
  endfunction

  task automatic scramble_inputs();
    for (int i = 0; i < N; i++) begin
      diff_to_all[i*W +: W]   = W'($urandom());
      z[i*W +: W]             = W'($urandom());
      predict_value[i*W +: W] = W'($urandom());
    end
    learning_rate = W'($urandom());
    w_layer_index = $urandom();
    w_row_index   = $urandom();
    is_cost_layer = 1'($urandom_range(0, 1));
    is_update     = 1'($urandom_range(0, 1));
  endtask

  task automatic drive_bundle();
    for (int i = 0; i < N; i++) begin
      diff_to_all[i*W +: W]   = s_d[i];
      z[i*W +: W]             = s_z[i];
      predict_value[i*W +: W] = s_p[i];
    end
    learning_rate = s_lr;
    is_cost_layer = s_cost;
    w_layer_index = s_wl;
    w_row_index   = s_wr;
    is_update     = s_upd;
    in_valid      = 1'b1;
  endtask

  // Present the bundle and return right after the accept edge.
  task automatic accept_bundle(input string name);
    int k;
    drive_bundle();
    k = 0;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check({name, "_in_ready_pre"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    scramble_inputs();
  endtask

  task automatic run_bundle(input string name, input logic [N*W-1:0] exp, input int hold);
    int lat;
    accept_bundle(name);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({name, "_latency"}, 64'(lat), 64'(N + 1));
    for (int i = 0; i < N; i++)
      check($sformatf("%s_delta%0d", name, i), 64'(delta[i*W +: W]), 64'(exp[i*W +: W]));
    check({name, "_layer_tag"}, 64'(w_layer_index_out), 64'(s_wl));
    check({name, "_row_tag"}, 64'(w_row_index_out), 64'(s_wr));
    check({name, "_upd_tag"}, 64'(is_update_out), 64'(s_upd));
    in_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      scramble_inputs();
      check($sformatf("%s_hold%0d_delta", name, h), 64'(delta), 64'(exp));
      check($sformatf("%s_hold%0d_tags", name, h),
            {31'd0, is_update_out, w_layer_index_out}, {31'd0, s_upd, s_wl});
      check($sformatf("%s_hold%0d_hs", name, h), 64'({out_valid, in_ready}), 64'(2'b10));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check({name, "_xfer_hs"}, 64'({out_valid, in_ready}), 64'(2'b10));
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, "_after_xfer_hs"}, 64'({out_valid, in_ready}), 64'(2'b01));
    $display("bundle %s cost=%0d lr=%h delta=%h latency=%0d hold=%0d",
             name, s_cost, s_lr, delta, lat, hold);
  endtask

  task automatic random_tags();
    s_wl  = $urandom();
    s_wr  = $urandom();
    s_upd = 1'($urandom_range(0, 1));
  endtask

  task automatic model_expect();
    for (int i = 0; i < N; i++)
      exp_vec[i*W +: W] = ref_delta(s_d[i], s_z[i], s_p[i], s_cost, s_lr);
  endtask

  initial begin
    int seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    scramble_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_hs", 64'({out_valid, in_ready}), 64'(2'b01));
    check("reset_delta", 64'(delta), 64'd0);
    check("reset_tags", {31'd0, is_update_out, w_layer_index_out}, 64'd0);
    check("reset_row_tag", 64'(w_row_index_out), 64'd0);

    // Hidden layer worked example, tag passthrough, 5-cycle backpressure.
    s_d = '{16'h0100, 16'h0200, 16'hFF00};
    s_z = '{16'h0080, 16'hFF00, 16'h0100};
    s_p = '{16'h1234, 16'h8000, 16'h7FFF};
    s_lr = 16'h0080; s_cost = 1'b0;
    s_wl = 32'd5; s_wr = 32'd17; s_upd = 1'b1;
    run_bundle("hidden", {16'hFF80, 16'h0000, 16'h0080}, 5);

    // Cost layer worked example (z = 0 element gates to zero).
    s_d = '{16'h7FFF, 16'h8000, 16'h4000};
    s_z = '{16'h0300, 16'h0100, 16'h0000};
    s_p = '{16'h0100, 16'h0200, 16'h0100};
    s_lr = 16'h0100; s_cost = 1'b1;
    random_tags();
    run_bundle("cost", {16'h0000, 16'hFF00, 16'h0200}, 0);

    // Positive and negative saturation.
    s_d = '{16'h7F00, 16'h7F00, 16'h7F00};
    s_z = '{16'h0100, 16'h0100, 16'h0100};
    s_lr = 16'h7F00; s_cost = 1'b0;
    random_tags();
    run_bundle("sat_pos", {16'h7FFF, 16'h7FFF, 16'h7FFF}, 1);
    s_d = '{16'h8000, 16'h8000, 16'h8000};
    random_tags();
    run_bundle("sat_neg", {16'h8000, 16'h8000, 16'h8000}, 0);

    // Reset two cycles after accept abandons the bundle.
    s_d = '{16'h0100, 16'h0200, 16'h0300};
    s_z = '{16'h0100, 16'h0100, 16'h0100};
    s_lr = 16'h0100; s_cost = 1'b0;
    random_tags();
    accept_bundle("rst_mid");
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_mid_hs", 64'({out_valid, in_ready}), 64'(2'b01));
    check("rst_mid_delta", 64'(delta), 64'd0);
    check("rst_mid_tags", {31'd0, is_update_out, w_layer_index_out}, 64'd0);
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("rst_mid_no_output", 64'(seen), 64'd0);
    $display("bundle rst_mid abandoned, out_valid cycles after reset=%0d", seen);

    // Bundle following the reset computes normally.
    s_d = '{16'h0180, 16'hFE00, 16'h0040};
    s_z = '{16'h0001, 16'h0200, 16'hFFFF};
    s_lr = 16'h0200; s_cost = 1'b0;
    random_tags();
    run_bundle("post_rst", {16'h0000, 16'hFC00, 16'h0300}, 0);

    // Randomized bundles against the reference model.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < N; i++) begin
        s_d[i] = W'($urandom());
        s_z[i] = W'($urandom());
        s_p[i] = W'($urandom());
        if (t % 2 == 0) begin
          s_d[i] = W'($signed(s_d[i]) >>> 6);
          s_p[i] = W'($signed(s_p[i]) >>> 4);
        end
        if ($urandom_range(0, 7) == 0) s_z[i] = '0;
      end
      s_lr   = (t % 3 == 0) ? W'($urandom()) : W'($urandom_range(0, 16'h0200));
      s_cost = 1'($urandom_range(0, 1));
      random_tags();
      model_expect();
      run_bundle($sformatf("rand%0d", t), exp_vec, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
